// File: rtl/ysyx_22050058_mul_ctrl_if.sv
// Bundle between the EXU-side multiply requester and its environment:
// EXU request/response channel plus the Booth/CSA multiplier handshake.
interface ysyx_22050058_mul_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int OP_W   = 3
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [OP_W-1:0]   op_i;
    logic              word_i;
    logic [DATA_W-1:0] src1_i;
    logic [DATA_W-1:0] src2_i;
    logic              flush_i;
    logic              resp_valid_o;
    logic              resp_ready_i;
    logic [DATA_W-1:0] resp_data_o;
    logic              busy_o;
    logic              mul_datavaild_o;
    logic [DATA_W-1:0] multiplicand_o;
    logic [DATA_W-1:0] multiplier_o;
    logic              mul_ready_o;
    logic              mul_mulvalid_i;
    logic [DATA_W-1:0] result_hi_i;
    logic [DATA_W-1:0] result_lo_i;

    modport slave (
        input  req_valid_i, op_i, word_i, src1_i, src2_i, flush_i, resp_ready_i,
               mul_mulvalid_i, result_hi_i, result_lo_i,
        output req_ready_o, resp_valid_o, resp_data_o, busy_o,
               mul_datavaild_o, multiplicand_o, multiplier_o, mul_ready_o
    );

    modport master (
        output req_valid_i, op_i, word_i, src1_i, src2_i, flush_i, resp_ready_i,
               mul_mulvalid_i, result_hi_i, result_lo_i,
        input  req_ready_o, resp_valid_o, resp_data_o, busy_o,
               mul_datavaild_o, multiplicand_o, multiplier_o, mul_ready_o
    );
endinterface

// File: rtl/ysyx_22050058_mul_ctrl.sv
// RV64M multiply requester: issues one signed 64x64 request to the Booth/CSA
// multiplier, corrects the high half for unsigned forms and holds the result for EXU.
module ysyx_22050058_mul_ctrl #(
    parameter int DATA_W = 64,
    parameter int OP_W   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    ysyx_22050058_mul_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [OP_W-1:0]         r_op;
    logic                    r_word;
    logic [DATA_W-1:0]       r_resp_data;
    logic [1:0][DATA_W-1:0]  w_src;
    logic [1:0][DATA_W-1:0]  w_opnd;
    logic                    w_load;
    logic                    w_capture;
    logic                    w_word_eff;
    logic [DATA_W-1:0]       w_a;
    logic [DATA_W-1:0]       w_b;
    logic [DATA_W-1:0]       w_corr_a;
    logic [DATA_W-1:0]       w_corr_b;
    logic [DATA_W-1:0]       w_result;

    assign w_word_eff = bus.word_i && (bus.op_i == '0);
    assign w_src[0]   = bus.src1_i;
    assign w_src[1]   = bus.src2_i;
    assign w_a        = w_opnd[0];
    assign w_b        = w_opnd[1];

    // MULW operands are narrowed to sign-extended 32-bit values at latch time.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            logic [DATA_W-1:0] r_val;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_val <= '0;
                end else if (w_load) begin
                    r_val <= w_word_eff ? {{(DATA_W-32){w_src[gi][31]}}, w_src[gi][31:0]}
                                        : w_src[gi];
                end
            end
            assign w_opnd[gi] = r_val;
        end
    endgenerate

    // The multiplier is signed x signed; an operand with bit 63 set but meant
    // unsigned contributes an extra 2^64 * other operand to the product.
    assign w_corr_a = w_b[DATA_W-1] ? w_a : '0;
    assign w_corr_b = w_a[DATA_W-1] ? w_b : '0;

    always_comb begin
        w_result = bus.result_lo_i;
        case (r_op)
            OP_W'(1): w_result = bus.result_hi_i;
            OP_W'(2): w_result = bus.result_hi_i + w_corr_a;
            OP_W'(3): w_result = bus.result_hi_i + w_corr_a + w_corr_b;
            default: begin
                if (r_word) begin
                    w_result = {{(DATA_W-32){bus.result_lo_i[31]}}, bus.result_lo_i[31:0]};
                end
            end
        endcase
    end

    always_comb begin
        w_state_next        = r_state;
        w_load              = 1'b0;
        w_capture           = 1'b0;
        bus.req_ready_o     = 1'b0;
        bus.resp_valid_o    = 1'b0;
        bus.resp_data_o     = '0;
        bus.busy_o          = 1'b0;
        bus.mul_datavaild_o = 1'b0;
        bus.multiplicand_o  = '0;
        bus.multiplier_o    = '0;
        bus.mul_ready_o     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid_i && !bus.flush_i) begin
                    w_load       = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: w_state_next = bus.flush_i ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                // On a simultaneous flush the result is left pending for DRAIN to acknowledge.
                if (bus.flush_i) begin
                    w_state_next = S_DRAIN;
                end else if (bus.mul_mulvalid_i) begin
                    w_capture    = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.resp_ready_i || bus.flush_i) begin
                    w_state_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (bus.mul_mulvalid_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (!rst) begin
            bus.req_ready_o     = (r_state == S_IDLE);
            bus.busy_o          = (r_state != S_IDLE);
            bus.resp_valid_o    = (r_state == S_DONE);
            bus.mul_datavaild_o = (r_state == S_ISSUE);
            bus.mul_ready_o     = w_capture || ((r_state == S_DRAIN) && bus.mul_mulvalid_i);
            bus.resp_data_o     = r_resp_data;
            bus.multiplicand_o  = w_a;
            bus.multiplier_o    = w_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_word      <= 1'b0;
            r_resp_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_op   <= bus.op_i;
                r_word <= w_word_eff;
            end
            if (w_capture) begin
                r_resp_data <= w_result;
            end
        end
    end
endmodule
